// File: rtl/sram_controller.sv
// Memory-stage controller: turns one 32-bit load/store into two half-word accesses on a
// 16-bit asynchronous SRAM, holding ready low so the pipeline freezes while the access runs.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {StIdle, StAccLo, StAccHi, StDone} state_e;

  localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES);

  state_e      state;
  logic [3:0]  cnt;
  logic [16:0] word;
  logic [31:0] data;
  logic        is_wr;
  logic [31:0] offset;

  assign offset = address - BASE_ADDR;

  // All SRAM pins are registered so no port input reaches the pad combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= StIdle;
      cnt         <= '0;
      word        <= '0;
      data        <= '0;
      is_wr       <= 1'b0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          if (wr_en || rd_en) begin
            state       <= StAccLo;
            cnt         <= '0;
            word        <= offset[18:2];
            data        <= write_data;
            is_wr       <= wr_en;
            sram_addr   <= {offset[18:2], 1'b0};
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= !wr_en;
          end
        end
        StAccLo: begin
          if (cnt == LastCnt) begin
            if (!is_wr) read_data[15:0] <= sram_dq_in;
            state       <= StAccHi;
            cnt         <= '0;
            sram_addr   <= {word, 1'b1};
            sram_dq_out <= data[31:16];
            sram_dq_oe  <= is_wr;
            sram_we_n   <= !is_wr;
          end else begin
            cnt <= cnt + 4'd1;
            // Release the strobe one cycle early so address/data stay stable past its rise.
            if (cnt + 4'd1 == LastCnt) sram_we_n <= 1'b1;
          end
        end
        StAccHi: begin
          if (cnt == LastCnt) begin
            if (!is_wr) read_data[31:16] <= sram_dq_in;
            state      <= StDone;
            cnt        <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt + 4'd1 == LastCnt) sram_we_n <= 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    ready = 1'b0;
    case (state)
      StIdle:  ready = !(wr_en || rd_en);
      StDone:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: random loads/stores against a word-level reference memory,
// with a scoreboard monitor checking SRAM pin activity, stall length and loaded data.
module tb_sram_controller;

  localparam int unsigned   Wait = 1;
  localparam int            T    = Wait + 1;
  localparam logic [31:0]   Base = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  sram_controller #(
    .BASE_ADDR  (Base),
    .WAIT_CYCLES(Wait)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM device: write while strobe low, read combinationally.
  bit [15:0] sram [0:262143];
  always @(posedge clk) if (rst && !sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
  assign sram_dq_in = sram[sram_addr];

  typedef struct {
    bit          wr;
    logic [17:0] lo;
    logic [15:0] dlo;
    logic [15:0] dhi;
    logic [31:0] rd;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [logic [16:0]];
  logic [31:0] last_load = '0;
  bit          final_chk = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] a);
    return 17'((a - Base) >> 2);
  endfunction

  // Monitor / scoreboard
  int          stall = 0;
  logic [17:0] s_addr [64];
  logic        s_we   [64];
  logic        s_oe   [64];
  logic [15:0] s_dq   [64];

  always @(negedge clk) begin
    if (final_chk) chk("queue_empty", q.size(), 0);
    if (!rst) begin
      chk("rst_we_n", sram_we_n, 1);
      chk("rst_oe", sram_dq_oe, 0);
      chk("rst_read_data", read_data, 0);
      chk("rst_sram_addr", sram_addr, 0);
      chk("rst_dq_out", sram_dq_out, 0);
      chk("rst_ready", ready, 1);
      stall = 0;
    end else if (!ready) begin
      if (stall < 64) begin
        s_addr[stall] = sram_addr;
        s_we[stall]   = sram_we_n;
        s_oe[stall]   = sram_dq_oe;
        s_dq[stall]   = sram_dq_out;
      end
      stall++;
    end else if (stall > 0) begin
      if (q.size() == 0) begin
        chk("unexpected_access", 1, 0);
      end else begin
        exp_t e;
        int bad_addr, bad_we, bad_oe, bad_dq;
        e = q.pop_front();
        bad_addr = 0; bad_we = 0; bad_oe = 0; bad_dq = 0;
        chk("stall_len", stall, 2 * T + 1);
        for (int k = 1; k <= 2 * T; k++) begin
          if (k < stall && k < 64) begin
            if (s_addr[k] !== ((k <= T) ? e.lo : (e.lo | 18'd1))) bad_addr++;
            if (s_we[k] !== !(e.wr && k != T && k != 2 * T)) bad_we++;
            if (s_oe[k] !== e.wr) bad_oe++;
            if (e.wr && s_dq[k] !== ((k <= T) ? e.dlo : e.dhi)) bad_dq++;
          end
        end
        chk("acc_addr_bad_cycles", bad_addr, 0);
        chk("acc_we_n_bad_cycles", bad_we, 0);
        chk("acc_oe_bad_cycles", bad_oe, 0);
        chk("acc_dq_bad_cycles", bad_dq, 0);
        chk("done_we_n", sram_we_n, 1);
        chk("done_oe", sram_dq_oe, 0);
        chk("done_addr", sram_addr, e.lo | 18'd1);
        chk("read_data", read_data, e.rd);
      end
      stall = 0;
    end else begin
      chk("idle_we_n", sram_we_n, 1);
      chk("idle_oe", sram_dq_oe, 0);
    end
  end

  // Issue one access at posedge+1 and hold the enables until the DONE edge has passed.
  task automatic do_op(input bit w, input logic [31:0] a, input logic [31:0] d, input bit scr);
    exp_t        e;
    logic [16:0] wd;
    bit          r;
    int          n;
    wd    = word_of(a);
    e.wr  = w;
    e.lo  = {wd, 1'b0};
    e.dlo = d[15:0];
    e.dhi = d[31:16];
    if (w) ref_mem[wd] = d;
    else last_load = ref_mem.exists(wd) ? ref_mem[wd] : 32'd0;
    e.rd = last_load;
    q.push_back(e);
    wr_en = w; rd_en = !w; address = a; write_data = d;
    n = 0;
    do begin
      @(negedge clk);
      r = ready;
      @(posedge clk);
      #1;
      if (scr) begin
        address    = $urandom;
        write_data = $urandom;
      end
      n++;
    end while (!r && n < 100);
    if (!r) begin
      $display("FAIL access_timeout: ready still 0 after %0d cycles, expected 1", n);
      $fatal(1);
    end
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    last_load = '0;
    idle(10);

    do_op(1'b1, 32'd1032, 32'hDEADBEEF, 1'b0);
    do_op(1'b0, 32'd1032, 32'h0, 1'b0);
    idle(2);

    do_op(1'b1, 32'd1024, 32'h12345678, 1'b0);
    do_op(1'b0, 32'd1024, 32'h0, 1'b0);
    idle(1);

    // Store aborted by reset in its third cycle; target word is never loaded afterwards.
    wr_en = 1'b1; rd_en = 1'b0; address = Base + 32'd800; write_data = $urandom;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    wr_en = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    last_load = '0;
    idle(2);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) a = Base - 32'd4 + 32'($urandom_range(0, 3));
      else a = Base + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      do_op(1'($urandom_range(0, 1)), a, $urandom, 1'b1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(3);
    final_chk = 1'b1;
    @(negedge clk);
    #1;
    final_chk = 1'b0;
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage controller that consumes the EXE/MEM pipeline register outputs (write-back/memory enables, ALU result as address, Rm value as store data) and performs 32-bit loads and stores on an external 16-bit asynchronous SRAM. Each word access takes two half-word SRAM accesses with programmable wait states. While an access is in flight the block drops `ready` so the hazard/freeze logic stalls every pipeline stage. On completion it presents the loaded word to the MEM/WB register.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: byte address of data-memory word 0; subtracted from `address`.
- `WAIT_CYCLES`, default 1: extra cycles per half-word access; legal range 1–15.

Ports:
- `clk`  input  1  rising-edge clock; single clock domain.
- `rst`  input  1  asynchronous, active-low reset.
- `wr_en`  input  1  store request (from EXE/MEM `mem_w_en`).
- `rd_en`  input  1  load request (from EXE/MEM `mem_r_en`).
- `address`  input  32  byte address (ALU result).
- `write_data`  input  32  store data (Rm value).
- `read_data`  output  32  loaded word; registered.
- `ready`  output  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline.
- `sram_addr`  output  18  SRAM half-word address.
- `sram_dq_out`  output  16  data driven to SRAM.
- `sram_dq_oe`  output  1  1 = `sram_dq_out` drives the bidirectional pad.
- `sram_dq_in`  input  16  data sampled from the SRAM pad.
- `sram_we_n`  output  1  SRAM write strobe, active-low.

## Operation
- Phase length T = WAIT_CYCLES+1 cycles.
- offset = (address − BASE_ADDR) mod 2^32; word = offset[18:2]; bits [1:0] ignored.
- Half-word addresses: low = {word,1'b0}, high = {word,1'b1}.
- States: IDLE, ACC_LO, ACC_HI, DONE. A 4-bit wait counter runs within each phase.
- IDLE:
  - On `wr_en|rd_en`: latch address, `write_data` and op, then go to ACC_LO.
  - `wr_en` has priority if both are high.
  - `ready` = !(wr_en|rd_en), combinational.
- ACC_LO: T cycles.
  - `sram_addr` = low address.
  - Write: `sram_dq_oe`=1, `sram_dq_out`=data[15:0], `sram_we_n`=0 on every cycle of the phase except the last.
  - Read: `sram_we_n`=1, `sram_dq_oe`=0; on the last cycle capture `sram_dq_in` into `read_data[15:0]`.
  - Then go to ACC_HI.
- ACC_HI: same as ACC_LO with the high address, data[31:16], and capture into `read_data[31:16]`. Then go to DONE.
- DONE: one cycle with `ready`=1 so the pipeline advances. Requests still asserted this cycle are ignored (no restart). Next state is unconditionally IDLE.
- `ready`=0 throughout ACC_LO and ACC_HI.
- `read_data` holds its value between loads; stores never modify it.
- SRAM pin outputs are decoded from registered state, counter and latches only; no input feeds them combinationally.
- Outside an access: `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr` = last driven value.

## Timing
- Reset (asynchronous, `rst`=0):
  - State IDLE, counter 0, `read_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1.
  - `ready`=1 when no request is present.
- Reset mid-access aborts immediately: `sram_we_n` goes high and `sram_dq_oe` low asynchronously. The partial word is discarded, so `read_data`=0.
- Request seen in cycle 0 (IDLE):
  - ACC_LO in cycles 1..T, ACC_HI in cycles T+1..2T, DONE in cycle 2T+1.
  - `ready` is low for 2T+1 cycles (0..2T) and high in cycle 2T+1.
  - `read_data` is valid from cycle 2T+1 until the next load completes.
- A request already present in DONE re-triggers only if it is still asserted in the following IDLE cycle.
- Back-to-back accesses (a new request in the IDLE cycle right after DONE) are accepted with zero bubble.
- Address, data and op are taken from the latches, not the ports, after cycle 0. Port changes during ACC_* have no effect.

## Test plan
- Reset then idle: `rst`=0 → all outputs at reset values; release with no request → `ready`=1, `sram_we_n`=1 held for 10 cycles.
- Store, WAIT_CYCLES=1, address=1032, write_data=0xDEADBEEF:
  - `sram_addr`=4 with `sram_dq_out`=0xBEEF for cycles 1–2, `sram_we_n`=0 in cycle 1 only.
  - `sram_addr`=5 with `sram_dq_out`=0xDEAD for cycles 3–4, `sram_we_n`=0 in cycle 3 only.
  - `ready` low in cycles 0–4, high in cycle 5.
- Load from the same address (SRAM model returns the stored data) → `read_data`=0xDEADBEEF in cycle 5; `sram_dq_oe`=0 and `sram_we_n`=1 throughout.
- Back-to-back: store 0x12345678 at 1024 then load 1024 with the enables held → second access starts the cycle after DONE; `read_data`=0x12345678; DONE never restarts an access.
- Reset mid-store: assert `rst` in cycle 2 → `sram_we_n`=1 and `sram_dq_oe`=0 immediately; after release state is IDLE and `read_data`=0.
- WAIT_CYCLES=3, load address 1028 → `sram_addr` 2 then 3, 4 cycles each; `ready` low for 9 cycles.
